// File: rtl/fx2_pkg.sv
// FX2 slave-FIFO bridge shared definitions: FSM states, FIFO addresses, command layout.
// No logic; constants and types only.
package fx2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_LEN2,
        ST_LEN3,
        ST_WRITE,
        ST_READ_ARM,
        ST_READ,
        ST_PKTEND
    } state_t;

    localparam logic [1:0] EP2_ADDR     = 2'b00;
    localparam logic [1:0] EP6_ADDR     = 2'b10;
    localparam int         CMD_READ_BIT = 7;

endpackage

// File: rtl/fx2_chan_bridge.sv
// FX2 slave-FIFO protocol engine: command/length decode on EP2, channel stream routing to/from EP6.
// Strobes are combinational on flags/handshake so a flag drop stalls the same cycle; state is registered.
import fx2_pkg::*;

module fx2_chan_bridge #(
    parameter int NUM_CHAN = 2,
    parameter int CHAN_W   = 7,
    parameter int PKT_SIZE = 512
) (
    input  logic              IFCLK,
    input  logic              RST,
    input  logic [7:0]        FDI,
    output logic [7:0]        FDO,
    output logic              FDS,
    output logic              SLRD,
    output logic              SLWR,
    output logic              SLOE,
    output logic [1:0]        ADDR,
    input  logic              FLAGB,
    input  logic              FLAGC,
    output logic              PKTEND,
    output logic [CHAN_W-1:0] chan_addr,
    output logic [7:0]        h2f_data,
    output logic              h2f_valid,
    input  logic              h2f_ready,
    input  logic [7:0]        f2h_data,
    input  logic              f2h_valid,
    output logic              f2h_ready
);

    localparam logic [31:0] NUM_CHAN_W = 32'(NUM_CHAN);
    localparam logic [31:0] PKT_MASK   = 32'(PKT_SIZE - 1);

    state_t              r_state;
    logic [31:0]         r_count;
    logic [CHAN_W-1:0]   r_chan;
    logic                r_read;
    logic                r_short;

    logic        w_chan_ok;
    logic        w_hdr_st;
    logic        w_ep6_st;
    logic        w_rd;
    logic        w_wr;
    logic        w_last;
    logic [31:0] w_len_next;

    assign w_chan_ok  = 32'(r_chan) < NUM_CHAN_W;
    assign w_hdr_st   = (r_state == ST_IDLE) || (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_LEN2) || (r_state == ST_LEN3);
    assign w_ep6_st   = (r_state == ST_READ_ARM) || (r_state == ST_READ) || (r_state == ST_PKTEND);
    assign w_len_next = {r_count[23:0], FDI};
    assign w_last     = (r_count == 32'd1);

    // Invalid channels still strobe so the host-side byte stream stays in sync.
    assign w_rd = !RST && FLAGC &&
                  (w_hdr_st || ((r_state == ST_WRITE) && (h2f_ready || !w_chan_ok)));
    assign w_wr = !RST && (r_state == ST_READ) && FLAGB && (f2h_valid || !w_chan_ok);

    assign SLRD      = !w_rd;
    assign SLWR      = !w_wr;
    assign SLOE      = !(!RST && (w_hdr_st || (r_state == ST_WRITE)));
    assign ADDR      = (!RST && w_ep6_st) ? EP6_ADDR : EP2_ADDR;
    assign FDS       = !RST && ((r_state == ST_READ_ARM) || (r_state == ST_READ));
    assign FDO       = (!RST && (r_state == ST_READ) && w_chan_ok) ? f2h_data : 8'h00;
    assign PKTEND    = !(!RST && (r_state == ST_PKTEND));
    assign h2f_data  = FDI;
    assign h2f_valid = !RST && (r_state == ST_WRITE) && FLAGC && w_chan_ok;
    assign f2h_ready = w_wr && w_chan_ok;
    assign chan_addr = r_chan;

    always_ff @(posedge IFCLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_count <= 32'd0;
            r_chan  <= '0;
            r_read  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (w_rd) begin
                    r_chan  <= FDI[CHAN_W-1:0];
                    r_read  <= FDI[CMD_READ_BIT];
                    r_count <= 32'd0;
                    r_state <= ST_LEN0;
                end
                ST_LEN0: if (w_rd) begin
                    r_count <= w_len_next;
                    r_state <= ST_LEN1;
                end
                ST_LEN1: if (w_rd) begin
                    r_count <= w_len_next;
                    r_state <= ST_LEN2;
                end
                ST_LEN2: if (w_rd) begin
                    r_count <= w_len_next;
                    r_state <= ST_LEN3;
                end
                ST_LEN3: if (w_rd) begin
                    r_count <= w_len_next;
                    r_short <= (w_len_next & PKT_MASK) != 32'd0;
                    if (w_len_next == 32'd0)
                        r_state <= ST_IDLE;
                    else if (r_read)
                        r_state <= ST_READ_ARM;
                    else
                        r_state <= ST_WRITE;
                end
                ST_WRITE: if (w_rd) begin
                    r_count <= r_count - 32'd1;
                    if (w_last)
                        r_state <= ST_IDLE;
                end
                ST_READ_ARM: r_state <= ST_READ;
                ST_READ: if (w_wr) begin
                    r_count <= r_count - 32'd1;
                    if (w_last)
                        r_state <= r_short ? ST_PKTEND : ST_IDLE;
                end
                ST_PKTEND: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fx2_chan_bridge.md
# fx2_chan_bridge

Parametrised FX2 slave-FIFO protocol engine: decodes host command packets on EP2 OUT and routes byte streams to/from up to NUM_CHAN FPGA-side channels over a valid/ready interface. Host-to-FPGA data comes from EP2; FPGA-to-host data goes to EP6, with short-packet commit via PKTEND. Sits between the FX2 pins and application register/FIFO logic, replacing fixed single-purpose top-level glue.

## Interface
- NUM_CHAN, 2: number of implemented channels (1..128)
- CHAN_W, 7: width of chan_addr (fixed by protocol; bits [6:0] of command)
- PKT_SIZE, 512: EP6 packet size in bytes, power of two; sets PKTEND rule
- IFCLK  in  1  FX2 interface clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- FDI  in  8  FX2 data bus, input side
- FDO  out  8  FX2 data bus, output side
- FDS  out  1  1 = drive FDO onto bus
- SLRD, SLWR, SLOE  out  1 each  FX2 strobes, active-low
- ADDR  out  2  FIFO select: 2'b00 = EP2 OUT, 2'b10 = EP6 IN
- FLAGB  in  1  EP6 IN has room (1 = not full)
- FLAGC  in  1  EP2 OUT has data (1 = not empty)
- PKTEND  out  1  active-low commit of short EP6 packet
- chan_addr  out  CHAN_W  channel of current transfer
- h2f_data / h2f_valid / h2f_ready  out 8 / out 1 / in 1  host→FPGA stream
- f2h_data / f2h_valid / f2h_ready  in 8 / in 1 / out 1  FPGA→host stream

## Operation
- Packet: command byte (bit7 = 1 read FPGA→host, 0 write host→FPGA; bits[6:0] channel), then 32-bit big-endian byte count, then payload (write only).
- States: IDLE → LEN0..LEN3 → (WRITE | READ_ARM → READ → PKTEND_ST) → IDLE.
- Byte fetch (IDLE, LEN0..3, WRITE): ADDR=00, SLOE=0; SLRD=0 in any cycle FLAGC=1 (WRITE additionally needs h2f_ready=1 or invalid channel); FDI sampled on that edge.
- WRITE: h2f_valid = FLAGC; h2f_data = FDI (combinational). Transfer when valid&&ready; count decrements. Channel ≥ NUM_CHAN: bytes consumed and dropped, h2f_valid held 0.
- READ_ARM: one turnaround cycle, ADDR=10, SLOE=1, FDS=1.
- READ: SLWR=0 in cycles FLAGB=1 and (f2h_valid=1 or invalid channel); f2h_ready high in the same cycle; FDO = f2h_data, or 8'h00 for invalid channel.
- After last read byte: if count mod PKT_SIZE ≠ 0 enter PKTEND_ST, PKTEND=0 one cycle; else straight to IDLE.
- Count 0: return to IDLE after LEN3, no data, no PKTEND.
- chan_addr latched from command byte, stable for whole transfer.

## Timing
- Reset values: SLRD=SLWR=SLOE=1, PKTEND=1, FDS=0, ADDR=00, FDO=00, h2f_valid=0, f2h_ready=0, chan_addr=0, state IDLE, count 0.
- RST mid-transfer: next cycle all outputs at reset values; remaining count discarded, no PKTEND.
- Throughput: one byte per cycle both directions when flags and handshake allow; no bubbles inside WRITE/READ.
- Command to first data byte: 5 fetch cycles (cmd + 4 len) minimum; reads add 1 turnaround cycle.
- Flag drop (FLAGC/FLAGB = 0) stalls strobes same cycle; state and count hold.
- FDS deasserts the cycle after the last SLWR; ADDR returns to 00 on IDLE entry.
- Count register 32 bits, unsigned; decrement only on completed byte.

## Structure
- Shared package fx2_pkg: state enum, EP2_ADDR=2'b00, EP6_ADDR=2'b10, CMD_READ_BIT=7.
- Single module; no natural sub-module (count, decode and FSM tightly coupled).

## Test plan
- Write ch1 len 3 {AA,BB,CC}, h2f_ready=1 → three h2f beats AA,BB,CC on chan_addr=1, SLRD low 8 cycles total, back to IDLE.
- Read ch0 len 4, f2h_data 10..13 → SLWR low 4 cycles with FDO 10..13 after 1 turnaround cycle, then PKTEND low 1 cycle.
- Read ch0 len 512 → 512 SLWR strobes, PKTEND never asserted.
- Write to ch 5 (NUM_CHAN=2) len 2 → 2 bytes consumed, h2f_valid stays 0; read ch 5 len 2 → FDO 00,00.
- FLAGB deasserted 3 cycles mid-read, then h2f_ready low 2 cycles mid-write → no strobes during stalls, no lost or duplicated bytes.
- RST asserted mid-write with count 100 remaining → next cycle reset values; fresh command then decodes correctly.
